// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: state encoding and address-map defaults for the MEM-stage SRAM controller
package mem_access_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
    localparam int CNT_W = 4;
endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// mem_access_ctrl_wait_counter: loadable down-counter that paces each halfword transfer
module mem_access_ctrl_wait_counter
    import mem_access_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk)
        if (!rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && !zero) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: splits one 32-bit load/store into two 16-bit SRAM transfers, freezing the pipeline meanwhile
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          SRAM_AW   = 18,
    parameter int          WAIT_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        val_Rm,
    output logic               freeze,
    output logic [31:0]        mem_rdata,
    output logic               done,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);
    state_t state, nxt;
    logic req, zero, busy, start, xfer_n, st_n, is_store, is_load, unused_off;
    logic [31:0] off, data, data_n;
    logic [SRAM_AW-2:0] hw, hw_n;
    logic [15:0] lo;

    assign req        = mem_read | mem_write;
    assign off        = alu_result - BASE_ADDR;
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
    assign busy       = state == LO || state == HI;
    assign start      = state == IDLE && req;
    assign freeze     = rst && (start || busy);
    assign done       = state == DONE;

    // In IDLE the request is still on the inputs, so outputs for the first LO cycle come from them directly
    assign hw_n   = state == IDLE ? off[SRAM_AW:2] : hw;
    assign data_n = state == IDLE ? val_Rm : data;
    assign st_n   = state == IDLE ? mem_write : is_store;
    assign xfer_n = nxt == LO || nxt == HI;

    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (req ? LO : IDLE) :
              state == LO   ? (zero ? HI : LO) :
              state == HI   ? (zero ? DONE : HI) : IDLE;
    end

    mem_access_ctrl_wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (start || (state == LO && zero)),
        .dec      (busy && !zero),
        .load_val (CNT_W'(WAIT_CYC)),
        .zero     (zero)
    );

    always_ff @(posedge clk)
        if (!rst) begin
            state       <= IDLE;
            mem_rdata   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            state      <= nxt;
            sram_we_n  <= !(xfer_n && st_n);
            sram_dq_oe <= xfer_n && st_n;
            if (xfer_n) begin
                sram_addr   <= {hw_n, nxt == HI};
                sram_dq_out <= nxt == HI ? data_n[31:16] : data_n[15:0];
            end
            if (state == HI && zero && is_load) mem_rdata <= {sram_dq_in, lo};
        end

    always_ff @(posedge clk) begin
        if (start) begin
            hw       <= off[SRAM_AW:2];
            data     <= val_Rm;
            is_store <= mem_write;
            is_load  <= mem_read && !mem_write;
        end
        if (state == LO && zero && is_load) lo <= sram_dq_in;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors against two controllers (WAIT_CYC=1 and WAIT_CYC=0) with SRAM models
module tb_mem_access_ctrl;
    logic clk = 0, rst = 0, mem_read = 0, mem_write = 0;
    logic [31:0] alu_result = 0, val_Rm = 0;
    logic freeze1, done1, we1, oe1, freeze0, done0, we0, oe0;
    logic [31:0] rd1, rd0;
    logic [17:0] sa1, sa0;
    logic [15:0] dqo1, dqo0, dqi1, dqi0;
    logic [15:0] mem1 [256];
    logic [15:0] mem0 [256];
    int n_vec = 0, n_bad = 0, dc1 = 0, fcnt = 0, base = 0;
    bit sel = 1;
    logic fz, dn, we, oe, any;
    logic [31:0] rd;
    logic [17:0] sa;
    logic [15:0] dq;
    logic [17:0] tr_a [8];
    logic        tr_we [8];
    logic        tr_oe [8];
    logic [15:0] tr_dq [8];

    always #5 clk = ~clk;

    mem_access_ctrl #(.WAIT_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .alu_result(alu_result), .val_Rm(val_Rm), .freeze(freeze1), .mem_rdata(rd1),
        .done(done1), .sram_addr(sa1), .sram_we_n(we1), .sram_dq_out(dqo1),
        .sram_dq_oe(oe1), .sram_dq_in(dqi1)
    );

    mem_access_ctrl #(.WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .alu_result(alu_result), .val_Rm(val_Rm), .freeze(freeze0), .mem_rdata(rd0),
        .done(done0), .sram_addr(sa0), .sram_we_n(we0), .sram_dq_out(dqo0),
        .sram_dq_oe(oe0), .sram_dq_in(dqi0)
    );

    always @(posedge clk) begin
        if (!we1 && oe1) mem1[sa1[7:0]] <= dqo1;
        if (!we0 && oe0) mem0[sa0[7:0]] <= dqo0;
        if (done1) dc1 <= dc1 + 1;
    end

    assign dqi1 = mem1[sa1[7:0]];
    assign dqi0 = mem0[sa0[7:0]];
    assign fz = sel ? freeze1 : freeze0;
    assign dn = sel ? done1 : done0;
    assign we = sel ? we1 : we0;
    assign oe = sel ? oe1 : oe0;
    assign rd = sel ? rd1 : rd0;
    assign sa = sel ? sa1 : sa0;
    assign dq = sel ? dqo1 : dqo0;

    task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    // Apply a request and trace every freeze cycle; returns at the first non-frozen negedge
    task go(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        mem_read = r; mem_write = w; alu_result = a; val_Rm = d;
        fcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!fz) break;
            if (fcnt < 8) begin
                tr_a[fcnt] = sa; tr_we[fcnt] = we; tr_oe[fcnt] = oe; tr_dq[fcnt] = dq;
            end
            fcnt++;
        end
    endtask

    initial begin
        tick; tick;
        @(negedge clk);
        chk("rst_freeze", fz, 0); chk("rst_we_n", we, 1); chk("rst_oe", oe, 0);
        chk("rst_addr", sa, 0); chk("rst_dq", dq, 0); chk("rst_done", dn, 0); chk("rst_rdata", rd, 0);
        tick; rst = 1;
        go(0, 1, 32'd1028, 32'hDEADBEEF);
        chk("st_freeze_cycles", fcnt, 5);
        chk("st_lo_addr_a", tr_a[1], 2); chk("st_lo_addr_b", tr_a[2], 2);
        chk("st_hi_addr_a", tr_a[3], 3); chk("st_hi_addr_b", tr_a[4], 3);
        chk("st_lo_we", tr_we[1], 0); chk("st_hi_we", tr_we[4], 0); chk("st_oe", tr_oe[2], 1);
        chk("st_lo_dq_a", tr_dq[1], 16'hBEEF); chk("st_lo_dq_b", tr_dq[2], 16'hBEEF);
        chk("st_hi_dq", tr_dq[3], 16'hDEAD);
        chk("st_done", dn, 1); chk("st_done_we", we, 1); chk("st_rdata", rd, 0);
        tick;
        go(1, 0, 32'd1028, 32'h0);
        chk("ld_freeze_cycles", fcnt, 5); chk("ld_we", tr_we[2], 1); chk("ld_oe", tr_oe[3], 0);
        chk("ld_hi_addr", tr_a[3], 3); chk("ld_done", dn, 1); chk("ld_rdata", rd, 32'hDEADBEEF);
        chk("sram_hw2", mem1[2], 16'hBEEF); chk("sram_hw3", mem1[3], 16'hDEAD);
        tick;
        mem_read = 0; mem_write = 0; any = 0;
        repeat (10) begin
            @(negedge clk);
            any = any | fz | !we | dn | oe;
        end
        chk("idle_quiet", any, 0); chk("idle_rdata", rd, 32'hDEADBEEF);
        tick;
        base = dc1;
        go(1, 0, 32'd1028, 32'h0);
        chk("b2b_ld_cycles", fcnt, 5); chk("b2b_ld_done", dn, 1);
        tick;
        go(0, 1, 32'd1036, 32'hCAFEF00D);
        chk("b2b_st_cycles", fcnt, 5); chk("b2b_st_addr", tr_a[1], 6);
        chk("b2b_st_done", dn, 1); chk("b2b_st_rdata", rd, 32'hDEADBEEF);
        tick;
        mem_write = 0;
        @(negedge clk); chk("b2b_no_retrigger", fz, 0);
        @(negedge clk); chk("b2b_no_extra_done", dn, 0);
        chk("b2b_done_count", dc1 - base, 2);
        chk("sram_hw6", mem1[6], 16'hF00D); chk("sram_hw7", mem1[7], 16'hCAFE);
        tick;
        mem_read = 1; alu_result = 32'd1036;
        repeat (4) @(negedge clk);
        chk("abort_in_hi", sa, 7); chk("abort_rdata_hold", rd, 32'hDEADBEEF);
        rst = 0;
        #1 chk("abort_freeze_comb", fz, 0);
        tick;
        mem_read = 0;
        chk("abort_we", we, 1); chk("abort_rdata", rd, 0); chk("abort_addr", sa, 0);
        rst = 1;
        @(negedge clk); chk("abort_idle_freeze", fz, 0);
        @(negedge clk); chk("abort_no_done", dn, 0); chk("abort_rdata_after", rd, 0);
        sel = 0; rst = 0;
        tick; tick;
        @(negedge clk);
        chk("w0_rst_rdata", rd, 0); chk("w0_rst_addr", sa, 0);
        tick; rst = 1;
        go(1, 1, 32'd1024, 32'hAABBCCDD);
        chk("w0_both_cycles", fcnt, 3); chk("w0_both_lo_addr", tr_a[1], 0);
        chk("w0_both_hi_addr", tr_a[2], 1); chk("w0_both_we", tr_we[1], 0);
        chk("w0_both_oe", tr_oe[2], 1); chk("w0_both_hi_dq", tr_dq[2], 16'hAABB);
        chk("w0_both_done", dn, 1); chk("w0_both_rdata", rd, 0);
        tick;
        go(1, 0, 32'd1024, 32'h0);
        chk("w0_ld_cycles", fcnt, 3); chk("w0_ld_we", tr_we[1], 1);
        chk("w0_ld_done", dn, 1); chk("w0_ld_rdata", rd, 32'hAABBCCDD);
        chk("w0_sram_hw0", mem0[0], 16'hCCDD);
        tick;
        mem_read = 0;
        @(negedge clk); chk("w0_idle_freeze", fz, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
